// File: rtl/boot_sequencer_pkg.sv
// ============================================================================
// Module : pwrctr_pkg
// Brief  : Shared types and constants for the DSP power/boot sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pwrctr_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    OFF      = 3'd0,
    PWR_WAIT = 3'd1,
    RST_HOLD = 3'd2,
    BOOT     = 3'd3,
    RUN      = 3'd4,
    PROG     = 3'd5,
    FAULT    = 3'd6
  } state_t;

  // EEPROM SPI bus owner
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DSP  = 2'd1,
    OWN_PROG = 2'd2
  } owner_t;

  // Boot-mode strap for SPI EEPROM boot
  localparam logic [3:0] BOOTCFG_DEFAULT = 4'b1001;

  // Largest of three timing parameters, used to size the state counter
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/boot_sequencer_sync2.sv
// ============================================================================
// Module : sync2
// Brief  : Two-flop synchronizer for one asynchronous input bit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage resampling into the clk_in domain
  always_ff @(posedge clk_in) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/boot_sequencer.sv
// ============================================================================
// Module : boot_sequencer
// Brief  : Supply enable, reset/strap sequencing and EEPROM SPI arbitration
//          for a DSP booting from SPI EEPROM; traps supply and boot faults.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module boot_sequencer
  import pwrctr_pkg::*;
#(
  parameter int         PWR_SETTLE_CYC   = 1000,
  parameter int         RST_HOLD_CYC     = 256,
  parameter int         BOOT_TIMEOUT_CYC = 1000000,
  parameter logic [3:0] BOOTCFG          = BOOTCFG_DEFAULT
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       pwr_good,
  input  logic       dsp_boot_done,
  input  logic       prog_req,
  output logic       pwr_en,
  output logic       dsp_rst_n,
  output logic [3:0] bootcfg,
  output logic       prog_gnt,
  output logic       fault,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs,
  output logic       miso,
  input  logic       prog_sclk,
  input  logic       prog_mosi,
  input  logic       prog_cs,
  output logic       prog_miso,
  output logic       eeprom_sclk,
  output logic       eeprom_mosi,
  output logic       eeprom_mem_cs,
  input  logic       eeprom_miso
);

  localparam int CNT_W = $clog2(max3(PWR_SETTLE_CYC, RST_HOLD_CYC, BOOT_TIMEOUT_CYC)) + 1;

  localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(PWR_SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_TIMEOUT_CYC - 1);

  // Synchronized control inputs; SPI chip selects idle high out of reset
  logic pwr_good_s, boot_done_s, prog_req_s, cs_s, prog_cs_s;

  sync2 #(.RESET_VAL(1'b0)) u_sync_pg   (.clk_in(clk_in), .rst(rst), .d(pwr_good),      .q(pwr_good_s));
  sync2 #(.RESET_VAL(1'b0)) u_sync_done (.clk_in(clk_in), .rst(rst), .d(dsp_boot_done), .q(boot_done_s));
  sync2 #(.RESET_VAL(1'b0)) u_sync_req  (.clk_in(clk_in), .rst(rst), .d(prog_req),      .q(prog_req_s));
  sync2 #(.RESET_VAL(1'b1)) u_sync_cs   (.clk_in(clk_in), .rst(rst), .d(cs),            .q(cs_s));
  sync2 #(.RESET_VAL(1'b1)) u_sync_pcs  (.clk_in(clk_in), .rst(rst), .d(prog_cs),       .q(prog_cs_s));

  state_t           state, state_next;
  owner_t           owner, owner_next;
  logic [CNT_W-1:0] count;
  logic             pwr_en_next, dsp_rst_n_next, prog_gnt_next, fault_next;

  // Next-state selection plus decode of the registered outputs from it
  always_comb begin
    state_next = state;
    unique case (state)
      OFF:      state_next = PWR_WAIT;
      PWR_WAIT: if (count == PWR_LAST) state_next = pwr_good_s ? RST_HOLD : FAULT;
      RST_HOLD: if (count == RST_LAST) state_next = BOOT;
      BOOT: begin
        if (boot_done_s)              state_next = RUN;
        else if (count == BOOT_LAST)  state_next = FAULT;
      end
      RUN:      if (prog_req_s && cs_s)       state_next = PROG;
      PROG:     if (!prog_req_s && prog_cs_s) state_next = RST_HOLD;
      FAULT:    state_next = FAULT;
      default:  state_next = OFF;
    endcase

    // Loss of the rail overrides any other move once the DSP is powered
    if (!pwr_good_s && (state == RST_HOLD || state == BOOT || state == RUN || state == PROG))
      state_next = FAULT;

    pwr_en_next    = (state_next != OFF) && (state_next != FAULT);
    dsp_rst_n_next = (state_next == BOOT) || (state_next == RUN);
    prog_gnt_next  = (state_next == PROG);
    fault_next     = (state_next == FAULT);

    unique case (state_next)
      BOOT, RUN: owner_next = OWN_DSP;
      PROG:      owner_next = OWN_PROG;
      default:   owner_next = OWN_NONE;
    endcase
  end

  // State, counter, owner and output registers; counter restarts on every state change
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state     <= OFF;
      count     <= '0;
      owner     <= OWN_NONE;
      pwr_en    <= 1'b0;
      dsp_rst_n <= 1'b0;
      prog_gnt  <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= (state_next != state) ? '0 : count + CNT_W'(1);
      owner     <= owner_next;
      pwr_en    <= pwr_en_next;
      dsp_rst_n <= dsp_rst_n_next;
      prog_gnt  <= prog_gnt_next;
      fault     <= fault_next;
    end
  end

  assign bootcfg = BOOTCFG;

  // SPI mux from the owner register and raw pins; reset parks the bus at once
  always_comb begin
    eeprom_sclk   = 1'b0;
    eeprom_mosi   = 1'b0;
    eeprom_mem_cs = 1'b1;
    miso          = 1'b0;
    prog_miso     = 1'b0;
    if (!rst) begin
      unique case (owner)
        OWN_DSP: begin
          eeprom_sclk   = sclk;
          eeprom_mosi   = mosi;
          eeprom_mem_cs = cs;
          miso          = eeprom_miso;
        end
        OWN_PROG: begin
          eeprom_sclk   = prog_sclk;
          eeprom_mosi   = prog_mosi;
          eeprom_mem_cs = prog_cs;
          prog_miso     = eeprom_miso;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_boot_sequencer.sv
// ============================================================================
// Module : tb_boot_sequencer
// Brief  : Randomized scoreboard bench for boot_sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_boot_sequencer;

  localparam int PS = 8;
  localparam int RH = 4;
  localparam int BT = 64;

  // Reference phases
  localparam int M_OFF = 0, M_PWR = 1, M_HOLD = 2, M_BOOT = 3, M_RUN = 4, M_PROG = 5, M_FAULT = 6;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1, pwr_good = 1'b0, dsp_boot_done = 1'b0, prog_req = 1'b0;
  logic       sclk = 1'b0, mosi = 1'b0, cs = 1'b1;
  logic       prog_sclk = 1'b0, prog_mosi = 1'b0, prog_cs = 1'b1, eeprom_miso = 1'b0;
  logic       pwr_en, dsp_rst_n, prog_gnt, fault, miso, prog_miso;
  logic       eeprom_sclk, eeprom_mosi, eeprom_mem_cs;
  logic [3:0] bootcfg;

  boot_sequencer #(
    .PWR_SETTLE_CYC(PS), .RST_HOLD_CYC(RH), .BOOT_TIMEOUT_CYC(BT), .BOOTCFG(4'b1001)
  ) dut (
    .clk_in(clk_in), .rst(rst), .pwr_good(pwr_good), .dsp_boot_done(dsp_boot_done),
    .prog_req(prog_req), .pwr_en(pwr_en), .dsp_rst_n(dsp_rst_n), .bootcfg(bootcfg),
    .prog_gnt(prog_gnt), .fault(fault), .sclk(sclk), .mosi(mosi), .cs(cs), .miso(miso),
    .prog_sclk(prog_sclk), .prog_mosi(prog_mosi), .prog_cs(prog_cs), .prog_miso(prog_miso),
    .eeprom_sclk(eeprom_sclk), .eeprom_mosi(eeprom_mosi), .eeprom_mem_cs(eeprom_mem_cs),
    .eeprom_miso(eeprom_miso)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic       pwr_en, dsp_rst_n, prog_gnt, fault;
    logic [3:0] bootcfg;
    logic       e_sclk, e_mosi, e_cs, miso, prog_miso;
  } obs_t;

  obs_t exp_q[$];
  int   compared = 0, mismatched = 0;

  // Requested control levels, applied to the pins at the next falling edge
  logic c_rst = 1'b1, c_pg = 1'b0, c_done = 1'b0, c_req = 1'b0;
  int   cs_mode = 0, pcs_mode = 0;   // 0 random, 1 held low, 2 held high
  bit   rand_ctl = 0;

  // Reference model: phase, edge time, time of phase entry, 2-stage input delay lines
  int   ph = M_OFF, t_now = 0, t_entry = 0;
  logic pg1, pg2, dn1, dn2, rq1, rq2, cs1, cs2, pc1, pc2;

  function automatic logic pick(input int mode);
    if (mode == 1) return 1'b0;
    if (mode == 2) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  // Advance the reference by one clock edge using the pin levels now applied
  task automatic model_edge();
    int nph, ticks;
    if (rst) begin
      ph = M_OFF; t_now = 0; t_entry = 0;
      {pg1, pg2, dn1, dn2, rq1, rq2} = '0;
      {cs1, cs2, pc1, pc2} = '1;
    end else begin
      t_now++;
      ticks = t_now - t_entry;
      nph   = ph;
      case (ph)
        M_OFF:  nph = M_PWR;
        M_PWR:  if (ticks == PS) nph = pg2 ? M_HOLD : M_FAULT;
        M_HOLD: if (ticks == RH) nph = M_BOOT;
        M_BOOT: if (dn2) nph = M_RUN; else if (ticks == BT) nph = M_FAULT;
        M_RUN:  if (rq2 && cs2) nph = M_PROG;
        M_PROG: if (!rq2 && pc2) nph = M_HOLD;
        default: nph = ph;
      endcase
      if (!pg2 && ph >= M_HOLD && ph <= M_PROG) nph = M_FAULT;
      if (nph != ph) t_entry = t_now;
      ph = nph;
      pg2 = pg1; pg1 = pwr_good;
      dn2 = dn1; dn1 = dsp_boot_done;
      rq2 = rq1; rq1 = prog_req;
      cs2 = cs1; cs1 = cs;
      pc2 = pc1; pc1 = prog_cs;
    end
  endtask

  function automatic obs_t expect_now();
    obs_t e;
    e.pwr_en    = !(ph == M_OFF || ph == M_FAULT);
    e.dsp_rst_n = (ph == M_BOOT || ph == M_RUN);
    e.prog_gnt  = (ph == M_PROG);
    e.fault     = (ph == M_FAULT);
    e.bootcfg   = 4'b1001;
    e.e_sclk = 1'b0; e.e_mosi = 1'b0; e.e_cs = 1'b1; e.miso = 1'b0; e.prog_miso = 1'b0;
    if (!rst && (ph == M_BOOT || ph == M_RUN)) begin
      e.e_sclk = sclk; e.e_mosi = mosi; e.e_cs = cs; e.miso = eeprom_miso;
    end else if (!rst && ph == M_PROG) begin
      e.e_sclk = prog_sclk; e.e_mosi = prog_mosi; e.e_cs = prog_cs; e.prog_miso = eeprom_miso;
    end
    return e;
  endfunction

  // Drive n cycles; each cycle queues the response expected after the next edge
  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk_in);
      if (rand_ctl) begin
        c_rst  = ($urandom_range(0, 199) == 0);
        c_pg   = ($urandom_range(0, 99) != 0);
        c_done = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 9) == 0) c_req = ~c_req;
      end
      rst = c_rst; pwr_good = c_pg; dsp_boot_done = c_done; prog_req = c_req;
      sclk = 1'($urandom_range(0, 1)); mosi = 1'($urandom_range(0, 1));
      prog_sclk = 1'($urandom_range(0, 1)); prog_mosi = 1'($urandom_range(0, 1));
      eeprom_miso = 1'($urandom_range(0, 1));
      cs = pick(cs_mode); prog_cs = pick(pcs_mode);
      model_edge();
      exp_q.push_back(expect_now());
    end
  endtask

  task automatic do_reset();
    c_rst = 1'b1; run(3); c_rst = 1'b0;
  endtask

  // Monitor: after every rising edge compare the DUT with the oldest expectation
  obs_t m_exp, m_act;
  initial begin
    forever begin
      @(posedge clk_in);
      #1;
      if (exp_q.size() != 0) begin
        m_exp = exp_q.pop_front();
        m_act = '{pwr_en, dsp_rst_n, prog_gnt, fault, bootcfg,
                  eeprom_sclk, eeprom_mosi, eeprom_mem_cs, miso, prog_miso};
        compared++;
        if (m_act !== m_exp) begin
          mismatched++;
          $display("FAIL outputs t=%0t phase=%0d actual=%b required=%b", $time, ph, m_act, m_exp);
        end
      end
    end
  end

  initial begin
    // Nominal boot, then arbitration and a re-boot
    do_reset();
    c_pg = 1'b1;
    run(20);
    c_done = 1'b1; run(1); c_done = 1'b0;
    run(20);
    cs_mode = 1; c_req = 1'b1;
    run($urandom_range(5, 15));
    cs_mode = 2;
    run(10);
    cs_mode = 0; pcs_mode = 0;
    run(20);
    pcs_mode = 1; c_req = 1'b0;
    run(6);
    pcs_mode = 2;
    run(8);
    c_done = 1'b1; run(1); c_done = 1'b0;
    run(10);

    // Power loss coinciding with release of the programming request
    c_req = 1'b1; cs_mode = 2;
    run(10);
    c_req = 1'b0; c_pg = 1'b0;
    run(12);
    pcs_mode = 0; cs_mode = 0;

    // No power at all
    do_reset();
    c_pg = 1'b0;
    run(30);

    // Boot timeout
    do_reset();
    c_pg = 1'b1;
    run(100);

    // Reset in the middle of BOOT
    do_reset();
    run(16);
    c_rst = 1'b1; run(2); c_rst = 1'b0;
    run(20);

    // Randomized control episodes
    for (int ep = 0; ep < 8; ep++) begin
      rand_ctl = 0; c_req = 1'b0; c_done = 1'b0; c_pg = 1'b1;
      do_reset();
      rand_ctl = 1;
      run(200);
    end
    rand_ctl = 0;

    @(posedge clk_in);
    #2;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/boot_sequencer.md
# boot_sequencer

Power-up, reset and boot sequencer for the TMS320VC5509A, hosted in the board CPLD. Enables the DSP supply rail, checks power-good, holds the DSP in reset while strapping bootcfg, then releases it to SPI-boot from the EEPROM. It also arbitrates the EEPROM SPI bus between the DSP and an external programming port, and traps supply faults.

## Interface
- PWR_SETTLE_CYC, 1000: cycles in PWR_WAIT before power-good is checked (≥2).
- RST_HOLD_CYC, 256: cycles dsp_rst_n is held low with bootcfg stable (≥1).
- BOOT_TIMEOUT_CYC, 1000000: maximum cycles in BOOT before FAULT.
- BOOTCFG, 4'b1001: boot-mode strap value (SPI EEPROM boot).

Ports:
- clk_in  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pwr_good  in  1  rail power-good, asynchronous
- dsp_boot_done  in  1  DSP GPIO, high once the boot image is loaded; asynchronous
- prog_req  in  1  programming port requests the EEPROM; asynchronous
- pwr_en  out  1  rail enable
- dsp_rst_n  out  1  DSP reset, active low
- bootcfg  out  4  boot-mode straps
- prog_gnt  out  1  programming port owns the EEPROM
- fault  out  1  sticky supply or boot fault
- sclk, mosi, cs  in  1 each  DSP SPI master
- miso  out  1  to the DSP
- prog_sclk, prog_mosi, prog_cs  in  1 each  programming-port SPI master
- prog_miso  out  1  to the programming port
- eeprom_sclk, eeprom_mosi, eeprom_mem_cs  out  1 each  to the EEPROM
- eeprom_miso  in  1  from the EEPROM

## Operation
- pwr_good, dsp_boot_done, prog_req, cs and prog_cs each pass through a 2-flop synchronizer. All decisions use the synchronized values.
- One state counter. It clears on every state entry. A timed state exits when count == N-1, so the state lasts exactly N cycles.

States:
- OFF: held while rst is high. Moves to PWR_WAIT on the first edge with rst low.
- PWR_WAIT: pwr_en=1. After PWR_SETTLE_CYC cycles, moves to RST_HOLD if pwr_good is high, otherwise to FAULT.
- RST_HOLD: dsp_rst_n=0. Moves to BOOT after RST_HOLD_CYC cycles.
- BOOT: dsp_rst_n=1 and the DSP owns the bus. Moves to RUN on dsp_boot_done. Moves to FAULT if the counter reaches BOOT_TIMEOUT_CYC-1 without dsp_boot_done.
- RUN: the DSP owns the bus. Moves to PROG when prog_req is high and the DSP cs is high (bus idle).
- PROG: dsp_rst_n=0, prog_gnt=1, and the programming port owns the bus. Moves to RST_HOLD (a re-boot) when prog_req is low and prog_cs is high. While prog_cs is low, the block stays in PROG even if prog_req drops.
- FAULT: pwr_en=0, dsp_rst_n=0, fault=1, prog_gnt=0. Only rst exits this state.
- Power loss: pwr_good going low in RST_HOLD, BOOT, RUN or PROG forces FAULT. This has priority over every other transition in the same cycle.

Bus ownership:
- An owner register takes one of NONE, DSP or PROG. It is updated on the same edge as the state change.
- The SPI mux is combinational from the owner register and the raw pins. This adds zero latency to the SPI paths.
- NONE: eeprom_mem_cs=1, eeprom_sclk=0, eeprom_mosi=0, miso=0, prog_miso=0. Applies in OFF, PWR_WAIT, RST_HOLD and FAULT.
- DSP (BOOT and RUN): eeprom_* connect to sclk/mosi/cs, miso=eeprom_miso, prog_miso=0.
- PROG: eeprom_* connect to prog_*, prog_miso=eeprom_miso, miso=0.

Straps:
- bootcfg=BOOTCFG in all states, including reset.

## Timing
- Reset values of registered outputs: pwr_en=0, dsp_rst_n=0, prog_gnt=0, fault=0, owner=NONE.
- Reset values of the other outputs: bootcfg=BOOTCFG; the bus-gated outputs take their NONE values.
- pwr_en, dsp_rst_n, prog_gnt and fault are registered decodes of the next state, so they change on the same edge as the state.
- Edge 0 is the first edge with rst low.
  - pwr_en rises after edge 0.
  - dsp_rst_n rises after edge PWR_SETTLE_CYC+RST_HOLD_CYC.
- Synchronized inputs add 2 cycles of latency:
  - a pwr_good drop reaches FAULT 3 edges after the drop;
  - prog_gnt rises 3 edges after prog_req, if cs is already idle.
- rst asserted in any state returns the block to OFF on the next edge. The bus drops to NONE immediately, even mid-SPI-transfer.

## Structure
- Package pwrctr_pkg holds:
  - the state enum (OFF, PWR_WAIT, RST_HOLD, BOOT, RUN, PROG, FAULT);
  - the owner encoding (NONE, DSP, PROG);
  - the BOOTCFG default constant.
- Sub-module sync2: a 2-flop synchronizer, instantiated five times.
- The counter width is $clog2 of the largest timing parameter, plus 1.

## Test plan
Parameters for all scenarios: PWR_SETTLE_CYC=8, RST_HOLD_CYC=4, BOOT_TIMEOUT_CYC=64.

- Nominal boot: hold pwr_good high, pulse dsp_boot_done at cycle 20 → pwr_en=1 after edge 0, dsp_rst_n=1 after edge 12, RUN reached, DSP SPI bytes pass through, bootcfg=4'b1001 throughout.
- No power: hold pwr_good low → FAULT after edge 8, pwr_en=0, fault=1, eeprom_mem_cs=1; stays in FAULT until rst.
- Boot timeout: never assert dsp_boot_done → FAULT 64 cycles after BOOT entry.
- Programming arbitration: assert prog_req while the DSP cs is low → no grant until cs rises; then prog_gnt=1 3 edges later, dsp_rst_n=0, and prog SPI traffic reaches the EEPROM. Drop prog_req with prog_cs high → RST_HOLD for 4 cycles, then BOOT.
- Priority and reset: drop pwr_good in PROG on the same cycle prog_req drops → FAULT, not RST_HOLD. Assert rst mid-BOOT → all outputs return to their reset values on the next edge.
